// File: rtl/dice_ctrl.sv
// Dice game controller: rolls a free-running die on button release and trades
// decisions with an external chooser. Optional roll limit: define DICE_CTRL_TURN_LIMIT_EN.
module dice_ctrl #(
    parameter int TURN_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       roll,
    input  logic       resp_pulse,
    input  logic [1:0] resp_result,
    input  logic [3:0] resp_score,
    output logic       pulse_o,
    output logic [2:0] num_o,
    output logic [3:0] score_o,
    output logic [3:0] rolls_o,
    output logic       playing_o,
    output logic       won_o,
    output logic       lost_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_ROLLING   = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_RESP = 3'd4,
        S_WON       = 3'd5,
        S_LOST      = 3'd6
    } state_t;

    localparam logic [1:0] RES_CONTINUE = 2'b00;
    localparam logic [1:0] RES_LOST     = 2'b01;
    localparam logic [1:0] RES_WON      = 2'b10;

    state_t     state_q, state_d;
    logic [2:0] die_q, die_d;
    logic [2:0] num_q, num_d;
    logic [3:0] score_q, score_d;
    logic [3:0] rolls_q, rolls_d;
    logic       pulse_q, pulse_d;
    logic       playing_q, playing_d;
    logic       won_q, won_d;
    logic       lost_q, lost_d;
    logic       limit_hit_s;

`ifdef DICE_CTRL_TURN_LIMIT_EN
    assign limit_hit_s = (rolls_q == 4'(TURN_LIMIT));
`else
    assign limit_hit_s = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            die_q     <= 3'd1;
            num_q     <= 3'd1;
            score_q   <= 4'd0;
            rolls_q   <= 4'd0;
            pulse_q   <= 1'b0;
            playing_q <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            die_q     <= die_d;
            num_q     <= num_d;
            score_q   <= score_d;
            rolls_q   <= rolls_d;
            pulse_q   <= pulse_d;
            playing_q <= playing_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start) state_d = S_PLAY;
                else       state_d = state_q;
            end
            S_PLAY: begin
                if (roll) state_d = S_ROLLING;
                else      state_d = S_PLAY;
            end
            S_ROLLING: begin
                if (!roll) state_d = S_ISSUE;
                else       state_d = S_ROLLING;
            end
            S_ISSUE: state_d = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (resp_pulse) begin
                    case (resp_result)
                        RES_CONTINUE: state_d = limit_hit_s ? S_LOST : S_PLAY;
                        RES_WON:      state_d = S_WON;
                        RES_LOST:     state_d = S_LOST;
                        default:      state_d = S_WAIT_RESP;
                    endcase
                end else begin
                    state_d = S_WAIT_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; pulse and flags follow the next state
    always_comb begin
        die_d   = (die_q == 3'd6) ? 3'd1 : die_q + 3'd1;
        num_d   = num_q;
        score_d = score_q;
        rolls_d = rolls_q;
        case (state_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start) begin
                    score_d = 4'd0;
                    rolls_d = 4'd0;
                end else begin
                    score_d = score_q;
                end
            end
            S_ROLLING: begin
                if (!roll) num_d = die_q;
                else       num_d = num_q;
            end
            S_ISSUE: begin
                if (rolls_q != 4'd15) rolls_d = rolls_q + 4'd1;
                else                  rolls_d = rolls_q;
            end
            S_WAIT_RESP: begin
                if (resp_pulse && (resp_result == RES_CONTINUE || resp_result == RES_WON))
                    score_d = resp_score;
                else
                    score_d = score_q;
            end
            default: num_d = num_q;
        endcase
        pulse_d   = (state_d == S_ISSUE);
        playing_d = (state_d == S_PLAY) || (state_d == S_ROLLING) ||
                    (state_d == S_ISSUE) || (state_d == S_WAIT_RESP);
        won_d     = (state_d == S_WON);
        lost_d    = (state_d == S_LOST);
    end

    assign pulse_o   = pulse_q;
    assign num_o     = num_q;
    assign score_o   = score_q;
    assign rolls_o   = rolls_q;
    assign playing_o = playing_q;
    assign won_o     = won_q;
    assign lost_o    = lost_q;

endmodule

// File: tb/tb_dice_ctrl.sv
// Directed testbench for dice_ctrl; honours DICE_CTRL_TURN_LIMIT_EN if defined.
module tb_dice_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       roll;
    logic       resp_pulse;
    logic [1:0] resp_result;
    logic [3:0] resp_score;
    logic       pulse_o;
    logic [2:0] num_o;
    logic [3:0] score_o;
    logic [3:0] rolls_o;
    logic       playing_o;
    logic       won_o;
    logic       lost_o;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] die_m;

    dice_ctrl #(.TURN_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .roll(roll),
        .resp_pulse(resp_pulse), .resp_result(resp_result), .resp_score(resp_score),
        .pulse_o(pulse_o), .num_o(num_o), .score_o(score_o), .rolls_o(rolls_o),
        .playing_o(playing_o), .won_o(won_o), .lost_o(lost_o)
    );

    always #5 clk = ~clk;

    // Reference die counter
    always @(posedge clk) begin
        if (rst) die_m <= 3'd1;
        else     die_m <= (die_m == 3'd6) ? 3'd1 : die_m + 3'd1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Press roll, release when the die shows target, then step through ISSUE
    task automatic do_roll(input logic [2:0] target, input logic [3:0] exp_rolls);
        int guard;
        roll = 1'b1;
        tick();
        guard = 0;
        while (die_m != target && guard < 8) begin
            tick();
            guard++;
        end
        roll = 1'b0;
        tick();
        check("issue_pulse", {7'd0, pulse_o}, 8'd1);
        check("issue_num", {5'd0, num_o}, {5'd0, target});
        tick();
        check("wait_pulse_low", {7'd0, pulse_o}, 8'd0);
        check("wait_rolls", {4'd0, rolls_o}, {4'd0, exp_rolls});
    endtask

    task automatic respond(input logic [1:0] res, input logic [3:0] sc);
        resp_pulse  = 1'b1;
        resp_result = res;
        resp_score  = sc;
        tick();
        resp_pulse  = 1'b0;
        resp_result = 2'b00;
        resp_score  = 4'd0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; roll = 1'b0;
        resp_pulse = 1'b0; resp_result = 2'b00; resp_score = 4'd0;
        tick(); tick(); tick();
        check("rst_flags", {5'd0, playing_o, won_o, lost_o}, 8'd0);
        check("rst_num", {5'd0, num_o}, 8'd1);
        check("rst_score", {4'd0, score_o}, 8'd0);
        check("rst_rolls", {4'd0, rolls_o}, 8'd0);
        check("rst_pulse", {7'd0, pulse_o}, 8'd0);
        rst = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        check("start_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);
        check("start_score", {4'd0, score_o}, 8'd0);
        check("start_rolls", {4'd0, rolls_o}, 8'd0);

        do_roll(3'd4, 4'd1);
        respond(2'b00, 4'd4);
        check("cont_score", {4'd0, score_o}, 8'd4);
        check("cont_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);

        // Response outside WAIT_RESP is ignored
        respond(2'b10, 4'd15);
        check("stray_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);
        check("stray_score", {4'd0, score_o}, 8'd4);

        do_roll(3'd2, 4'd2);
        respond(2'b11, 4'd7);
        tick();
        check("rsv_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);
        check("rsv_score", {4'd0, score_o}, 8'd4);
        check("rsv_pulse", {7'd0, pulse_o}, 8'd0);
        respond(2'b00, 4'd9);
        check("cont9_score", {4'd0, score_o}, 8'd9);

        do_roll(3'd6, 4'd3);
        respond(2'b10, 4'd15);
        check("won_flags", {5'd0, playing_o, won_o, lost_o}, 8'b010);
        check("won_score", {4'd0, score_o}, 8'd15);

        roll = 1'b1; tick(); roll = 1'b0; tick(); tick();
        check("won_roll_ign", {5'd0, playing_o, won_o, lost_o}, 8'b010);
        check("won_roll_pulse", {7'd0, pulse_o}, 8'd0);
        check("won_num_hold", {5'd0, num_o}, 8'd6);

        start = 1'b1; tick(); start = 1'b0;
        check("restart_score", {4'd0, score_o}, 8'd0);
        check("restart_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);
        check("restart_rolls", {4'd0, rolls_o}, 8'd0);

        do_roll(3'd1, 4'd1);
        respond(2'b00, 4'd5);
        do_roll(3'd3, 4'd2);
        respond(2'b01, 4'd12);
        check("lost_flags", {5'd0, playing_o, won_o, lost_o}, 8'b001);
        check("lost_score", {4'd0, score_o}, 8'd5);

        start = 1'b1; tick(); start = 1'b0;
`ifdef DICE_CTRL_TURN_LIMIT_EN
        for (int i = 1; i <= 8; i++) begin
            do_roll(3'((i % 6) + 1), 4'(i));
            respond(2'b00, 4'(i));
            if (i == 7)
                check("limit_7_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);
        end
        check("limit_8_flags", {5'd0, playing_o, won_o, lost_o}, 8'b001);
        check("limit_8_score", {4'd0, score_o}, 8'd8);
`else
        for (int i = 1; i <= 16; i++) begin
            do_roll(3'((i % 6) + 1), (i > 15) ? 4'd15 : 4'(i));
            respond(2'b00, 4'(i));
        end
        check("nolimit_flags", {5'd0, playing_o, won_o, lost_o}, 8'b100);
        check("nolimit_rolls", {4'd0, rolls_o}, 8'd15);
        check("nolimit_score", {4'd0, score_o}, 8'd0);
`endif

        // Reset while ISSUE is active
        start = 1'b1; tick(); start = 1'b0;
        roll = 1'b1; tick();
        while (die_m != 3'd5) tick();
        roll = 1'b0; tick();
        check("pre_rst_pulse", {7'd0, pulse_o}, 8'd1);
        check("pre_rst_num", {5'd0, num_o}, 8'd5);
        rst = 1'b1; tick();
        check("issue_rst_pulse", {7'd0, pulse_o}, 8'd0);
        check("issue_rst_flags", {5'd0, playing_o, won_o, lost_o}, 8'd0);
        check("issue_rst_num", {5'd0, num_o}, 8'd1);
        check("issue_rst_score", {4'd0, score_o}, 8'd0);
        check("issue_rst_rolls", {4'd0, rolls_o}, 8'd0);
        rst = 1'b0; tick(); tick();
        check("post_rst_pulse", {7'd0, pulse_o}, 8'd0);
        check("post_rst_flags", {5'd0, playing_o, won_o, lost_o}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dice_ctrl.md
DICE_CTRL -- requirements
Module: dice_ctrl

Interface
REQ-001 SHALL have parameter TURN_LIMIT, default 8, meaning the number of issued rolls after which a CONTINUE response ends the game as lost (used only with DICE_CTRL_TURN_LIMIT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  level button; begins a new game.
REQ-005 SHALL have port roll  input  1  level button; press then release rolls the die.
REQ-006 SHALL have port resp_pulse  input  1  one-cycle strobe from the chooser; resp_result/resp_score are valid on it.
REQ-007 SHALL have port resp_result  input  2  00 CONTINUE, 01 LOST, 10 WON, 11 reserved.
REQ-008 SHALL have port resp_score  input  4  chooser's updated score.
REQ-009 SHALL have port pulse_o  output  1  one-cycle strobe to the chooser requesting a decision.
REQ-010 SHALL have port num_o  output  3  rolled value, 1..6, held stable from pulse_o until the next roll.
REQ-011 SHALL have port score_o  output  4  current score, driven to the chooser.
REQ-012 SHALL have port rolls_o  output  4  rolls issued this game, saturating at 15.
REQ-013 SHALL have ports playing_o, won_o, lost_o  output  1 each  game status flags, one-hot or all zero.

Function
REQ-014 SHALL implement states IDLE, PLAY, ROLLING, ISSUE, WAIT_RESP, WON, LOST.
REQ-015 SHALL run a free-running die counter: value 1 after reset, +1 every cycle, 6 wraps to 1, independent of state.
REQ-016 IDLE/WON/LOST with start=1 SHALL go to PLAY next cycle and clear score_o and rolls_o to 0.
REQ-017 start SHALL be ignored in PLAY, ROLLING, ISSUE and WAIT_RESP.
REQ-018 PLAY with roll=1 SHALL go to ROLLING.
REQ-019 ROLLING with roll=0 SHALL latch the current die counter value into num_o and go to ISSUE.
REQ-020 ISSUE SHALL assert pulse_o for exactly one cycle, increment rolls_o (saturating at 15), and go to WAIT_RESP.
REQ-021 WAIT_RESP with resp_pulse=1 and CONTINUE SHALL load score_o from resp_score and return to PLAY.
REQ-022 WAIT_RESP with resp_pulse=1 and WON SHALL load score_o from resp_score and go to WON.
REQ-023 WAIT_RESP with resp_pulse=1 and LOST SHALL leave score_o unchanged and go to LOST.
REQ-024 WAIT_RESP with resp_pulse=1 and result 11 SHALL ignore the response and stay in WAIT_RESP.
REQ-025 resp_pulse in any state other than WAIT_RESP SHALL be ignored.
REQ-026 roll SHALL be ignored outside PLAY and ROLLING.
REQ-027 The flags SHALL be: playing_o=1 in PLAY, ROLLING, ISSUE and WAIT_RESP; won_o=1 only in WON; lost_o=1 only in LOST.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst=1 the block SHALL enter IDLE, with die counter=1, num_o=1, score_o=0, rolls_o=0, pulse_o=0 and all flags 0.
REQ-030 rst asserted mid-game, including in ISSUE or WAIT_RESP, SHALL take effect next edge and suppress any pending pulse_o.

Configuration
REQ-031 With macro DICE_CTRL_TURN_LIMIT_EN defined, a CONTINUE response received when rolls_o==TURN_LIMIT SHALL go to LOST instead of PLAY, with score_o still loaded.
REQ-032 With DICE_CTRL_TURN_LIMIT_EN undefined, there SHALL be no roll limit and TURN_LIMIT SHALL be unused.

Verification
REQ-033 Reset, start=1 for 1 cycle -> playing_o=1, score_o=0, rolls_o=0.
REQ-034 roll pressed then released on a cycle where the die counter is 4 -> num_o=4, pulse_o high exactly 1 cycle, rolls_o=1; then resp_pulse with CONTINUE, resp_score=4 -> score_o=4, state PLAY.
REQ-035 At score 9, resp WON with resp_score=15 -> won_o=1, score_o=15; a later start -> score_o=0, playing_o=1.
REQ-036 resp LOST -> lost_o=1 and score_o unchanged; resp_pulse in PLAY and result 11 in WAIT_RESP -> no state change.
REQ-037 With DICE_CTRL_TURN_LIMIT_EN defined and TURN_LIMIT=8, eight CONTINUE responses -> lost_o=1 after the 8th; with it undefined -> playing_o=1 and rolls_o saturates at 15.
REQ-038 rst asserted in ISSUE -> no pulse_o, IDLE, all outputs at reset values.
